// File: rtl/fixed_point_mul_array.sv
// Pipelined signed fixed-point multiplier array: LANES independent products per
// transaction with valid/ready flow control, lane masking, rounding and saturation.
module fixed_point_mul_array #(
  parameter int LANES     = 27,
  parameter int BITSIZE   = 14,
  parameter int FRAC_BITS = 7,
  parameter int OUT_W     = 2*BITSIZE - FRAC_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BITSIZE*LANES-1:0] data_in,
  input  logic [BITSIZE*LANES-1:0] weights,
  input  logic [LANES-1:0]         lane_en,
  input  logic                     rnd_mode,
  input  logic                     sat_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W*LANES-1:0]   mul_result,
  output logic [LANES-1:0]         ovf
);

  localparam int PW = 2*BITSIZE;           // full product width
  localparam int RW = PW + 1 - FRAC_BITS;  // scaled width (one guard bit for rounding)
  localparam int HW = RW - OUT_W + 1;      // bits that must agree for R to fit OUT_W

  localparam logic [PW:0]      RND_K   = (PW+1)'(1) << (FRAC_BITS-1);
  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // Sign-extend an operand to product width; the low PW bits of a PW x PW
  // product are then the correct two's complement result.
  function automatic logic [PW-1:0] sext(input logic [BITSIZE-1:0] x);
    return {{BITSIZE{x[BITSIZE-1]}}, x};
  endfunction

  logic [LANES-1:0][BITSIZE-1:0] a_lane, b_lane;
  assign a_lane = data_in;
  assign b_lane = weights;

  // Stage 1: raw products plus captured mode/mask
  logic                      s1_valid_q, s1_valid_d;
  logic [LANES-1:0][PW-1:0]  s1_prod_q,  s1_prod_d;
  logic [LANES-1:0]          s1_en_q,    s1_en_d;
  logic                      s1_rnd_q,   s1_rnd_d;
  logic                      s1_sat_q,   s1_sat_d;

  // Stage 2: scaled results and overflow flags
  logic                      s2_valid_q, s2_valid_d;
  logic [LANES-1:0][OUT_W-1:0] s2_res_q, s2_res_d;
  logic [LANES-1:0]          s2_ovf_q,   s2_ovf_d;

  logic s1_adv, s2_adv;

  logic [LANES-1:0][PW:0]    rnd_sum;
  logic [LANES-1:0][RW-1:0]  scaled;
  logic [LANES-1:0]          lane_ovf;

  always_comb begin
    s2_adv   = ~s2_valid_q | out_ready;
    s1_adv   = ~s1_valid_q | s2_adv;
    in_ready = s1_adv;
  end

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; that is what keeps these blocks free of inferred latches.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_prod_d  = s1_prod_q;
    s1_en_d    = s1_en_q;
    s1_rnd_d   = s1_rnd_q;
    s1_sat_d   = s1_sat_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
    end
    if (s1_adv && in_valid) begin
      for (int i = 0; i < LANES; i++) begin
        s1_prod_d[i] = sext(a_lane[i]) * sext(b_lane[i]);
      end
      s1_en_d  = lane_en;
      s1_rnd_d = rnd_mode;
      s1_sat_d = sat_en;
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      rnd_sum[i]  = {s1_prod_q[i][PW-1], s1_prod_q[i]} + (s1_rnd_q ? RND_K : '0);
      scaled[i]   = RW'($signed(rnd_sum[i]) >>> FRAC_BITS);
      lane_ovf[i] = ~(&scaled[i][RW-1 -: HW]) & (|scaled[i][RW-1 -: HW]);
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_ovf_d   = s2_ovf_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end
    // Payload only moves with a real transaction so the outputs hold between results.
    if (s2_adv && s1_valid_q) begin
      for (int i = 0; i < LANES; i++) begin
        if (!s1_en_q[i]) begin
          s2_res_d[i] = '0;
          s2_ovf_d[i] = 1'b0;
        end else if (lane_ovf[i] && s1_sat_q) begin
          s2_res_d[i] = scaled[i][RW-1] ? SAT_MIN : SAT_MAX;
          s2_ovf_d[i] = 1'b1;
        end else begin
          s2_res_d[i] = scaled[i][OUT_W-1:0];
          s2_ovf_d[i] = lane_ovf[i];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  // NOTE: the datapath registers are reset too, because mul_result and ovf
  // must read zero while reset is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_en_q    <= '0;
      s1_rnd_q   <= 1'b0;
      s1_sat_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_ovf_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_prod_q  <= s1_prod_d;
      s1_en_q    <= s1_en_d;
      s1_rnd_q   <= s1_rnd_d;
      s1_sat_q   <= s1_sat_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_ovf_q   <= s2_ovf_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign mul_result = s2_res_q;
  assign ovf        = s2_ovf_q;

endmodule

// File: tb/tb_fixed_point_mul_array.sv
// Directed bench for fixed_point_mul_array: 4 lanes, Q6.7 inputs, 16-bit outputs,
// covering scaling modes, saturation, masking, backpressure and mid-flight reset.
module tb_fixed_point_mul_array;

  localparam int LANES     = 4;
  localparam int BITSIZE   = 14;
  localparam int FRAC_BITS = 7;
  localparam int OUT_W     = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic [BITSIZE*LANES-1:0] data_in;
  logic [BITSIZE*LANES-1:0] weights;
  logic [LANES-1:0]         lane_en;
  logic                     rnd_mode;
  logic                     sat_en;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_W*LANES-1:0]   mul_result;
  logic [LANES-1:0]         ovf;

  int n_vec = 0;
  int n_err = 0;

  fixed_point_mul_array #(
    .LANES(LANES), .BITSIZE(BITSIZE), .FRAC_BITS(FRAC_BITS), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .weights(weights),
    .lane_en(lane_en), .rnd_mode(rnd_mode), .sat_en(sat_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .mul_result(mul_result), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [55:0] rep(input logic [13:0] v);
    return {4{v}};
  endfunction

  // One transaction into an empty pipeline with out_ready high: the result must
  // be absent one cycle after acceptance and present two cycles after.
  task automatic one_shot(input string tag, input logic [55:0] a, input logic [55:0] b,
                          input logic [3:0] en, input logic rnd, input logic sat,
                          input logic [63:0] exp_res, input logic [3:0] exp_ovf);
    @(negedge clk);
    data_in = a; weights = b; lane_en = en; rnd_mode = rnd; sat_en = sat;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 check({tag, " in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; data_in = '1; weights = '1; lane_en = ~en; rnd_mode = ~rnd; sat_en = ~sat;
    check({tag, " early"}, out_valid, 0);
    @(negedge clk);
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " result"}, mul_result, exp_res);
    check({tag, " ovf"}, ovf, exp_ovf);
  endtask

  // Backpressure stream: hand-computed results for each transaction
  logic [13:0] t_a   [6] = '{14'h0040, 14'h3FC0, 14'h0003, 14'h1FFF, 14'h1FFF, 14'h3F40};
  logic [13:0] t_b   [6] = '{14'h0001, 14'h0001, 14'h0040, 14'h1FFF, 14'h1FFF, 14'h0100};
  logic [3:0]  t_en  [6] = '{4'b1111, 4'b1111, 4'b0011, 4'b1111, 4'b0101, 4'b1111};
  logic        t_rnd [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        t_sat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [63:0] t_res [6] = '{64'h0001_0001_0001_0001, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'h0000_0000_0001_0001, 64'h7FFF_7FFF_7FFF_7FFF,
                             64'h0000_FF80_0000_FF80, 64'hFE80_FE80_FE80_FE80};
  logic [3:0]  t_ovf [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0101, 4'b0000};

  initial begin
    int sent, got, cyc;
    logic stall_seen;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    data_in = '0; weights = '0; lane_en = '0; rnd_mode = 1'b0; sat_en = 1'b0;
    #2;
    check("reset out_valid", out_valid, 0);
    check("reset mul_result", mul_result, 0);
    check("reset ovf", ovf, 0);
    check("reset in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    one_shot("basic", rep(14'd192), rep(14'd256), 4'b1111, 1'b0, 1'b0,
             64'h0180_0180_0180_0180, 4'b0000);
    one_shot("trunc", {14'h0, 14'h0, 14'h3FFF, 14'h0001}, rep(14'd64), 4'b1111, 1'b0, 1'b0,
             64'h0000_0000_FFFF_0000, 4'b0000);
    one_shot("round", {14'h0, 14'h0, 14'h3FFF, 14'h0001}, rep(14'd64), 4'b1111, 1'b1, 1'b0,
             64'h0000_0000_0000_0001, 4'b0000);
    one_shot("sat", {14'h0, 14'h0, 14'h2000, 14'h1FFF}, {14'h0, 14'h0, 14'h1FFF, 14'h1FFF},
             4'b1111, 1'b0, 1'b1, 64'h0000_0000_8000_7FFF, 4'b0011);
    one_shot("wrap", {14'h0, 14'h0, 14'h2000, 14'h1FFF}, {14'h0, 14'h0, 14'h1FFF, 14'h1FFF},
             4'b1111, 1'b0, 1'b0, 64'h0000_0000_0040_FF80, 4'b0011);
    one_shot("mask", rep(14'd128), rep(14'd128), 4'b1010, 1'b0, 1'b1,
             64'h0080_0000_0080_0000, 4'b0000);
    one_shot("mask ovf", rep(14'h1FFF), rep(14'h1FFF), 4'b0101, 1'b0, 1'b1,
             64'h0000_7FFF_0000_7FFF, 4'b0101);

    // Backpressure: out_ready low for loop cycles 3..5; while an input is refused
    // the mode/mask pins are scrambled, which must not reach captured transactions.
    sent = 0; got = 0; cyc = 0; stall_seen = 1'b0;
    while (got < 6 && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 5);
      if (sent < 6) begin
        in_valid = 1'b1;
        data_in = rep(t_a[sent]); weights = rep(t_b[sent]);
        lane_en = t_en[sent]; rnd_mode = t_rnd[sent]; sat_en = t_sat[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check($sformatf("bp in_ready c%0d", cyc), in_ready, ((sent - got) < 2) || out_ready);
      if (in_valid && !in_ready) begin
        stall_seen = 1'b1;
        lane_en = ~lane_en; rnd_mode = ~rnd_mode; sat_en = ~sat_en;
      end else if (in_valid) begin
        sent++;
      end
      if (out_valid && out_ready) begin
        check($sformatf("bp result t%0d", got), mul_result, t_res[got]);
        check($sformatf("bp ovf t%0d", got), ovf, t_ovf[got]);
        got++;
      end
      cyc++;
    end
    check("bp all results", got, 6);
    check("bp in_ready dropped", stall_seen, 1);

    // Reset with two transactions in flight
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b0;
    data_in = rep(14'h1FFF); weights = rep(14'h1FFF); lane_en = 4'b1111; sat_en = 1'b1; rnd_mode = 1'b0;
    @(negedge clk);
    data_in = rep(14'd192); weights = rep(14'd256);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre-reset out_valid", out_valid, 1);
    rst = 1'b0;
    #1;
    check("mid reset out_valid", out_valid, 0);
    check("mid reset mul_result", mul_result, 0);
    check("mid reset ovf", ovf, 0);
    check("mid reset in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post reset idle %0d", i), out_valid, 0);
    end
    one_shot("after reset", rep(14'd192), rep(14'd256), 4'b1111, 1'b0, 1'b0,
             64'h0180_0180_0180_0180, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
